// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg
// Shared definitions for the iterative execute-stage ALU.
//   - ALUop codes. The ALU decoder uses the same values.
//   - Shift-mode enum used by the shift sub-module.
//   - Small helpers that classify an ALUop.
package alu_iter_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;
    localparam logic [3:0] ALU_XXX    = 4'd15;

    // Direction and fill rule for one shift step.
    typedef enum logic [1:0] {
        SH_LL = 2'd0,   // left, zero fill
        SH_RL = 2'd1,   // right, zero fill
        SH_RA = 2'd2    // right, sign fill
    } shift_mode_t;

    // True for the three ops that are executed one bit per cycle.
    function automatic logic is_shift_op(input logic [3:0] op);
        logic res;
        case (op)
            ALU_SLL, ALU_SRA, ALU_SRL: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

    // Maps a shift ALUop to its step rule. Non-shift ops map to SH_LL and are never loaded.
    function automatic shift_mode_t shift_mode_of(input logic [3:0] op);
        shift_mode_t res;
        case (op)
            ALU_SLL: res = SH_LL;
            ALU_SRL: res = SH_RL;
            ALU_SRA: res = SH_RA;
            default: res = SH_LL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if
// Operation/result handshake bundle between operand-select and the ALU.
//   in_valid/in_ready   : operation offer and acceptance
//   ALUop, A, B         : operation code and operands
//   out_valid/out_ready : result offer and consumption
//   result              : registered result
// The master is the pipeline side. The slave is the ALU.
interface alu_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUop;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, ALUop, A, B, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, ALUop, A, B, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu_iter_shift.sv
// alu_iter_shift
// Working register and bit counter for the iterative shifts.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture load_val/load_cnt/load_mode. Takes priority over step.
//   step       : shift the working register one bit and decrement the counter
//   step_val   : the working register value after the next step (combinational)
//   last_step  : the counter is at 1, so the next step completes the shift
module alu_iter_shift
    import alu_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [SHAMT_W-1:0] load_cnt,
    input  shift_mode_t        load_mode,
    output logic [WIDTH-1:0]   step_val,
    output logic               last_step
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]   work_r;
    logic [SHAMT_W-1:0] cnt_r;
    shift_mode_t        mode_r;

    // One-bit shift of the working register according to the latched mode.
    always_comb begin
        step_val = work_r;
        case (mode_r)
            SH_LL:   step_val = {work_r[WIDTH-2:0], 1'b0};
            SH_RL:   step_val = {1'b0, work_r[WIDTH-1:1]};
            SH_RA:   step_val = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
            default: step_val = work_r;
        endcase
    end

    assign last_step = (cnt_r == CNT_ONE);

    // Working register, counter and mode. Load takes priority over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r <= {WIDTH{1'b0}};
            cnt_r  <= {SHAMT_W{1'b0}};
            mode_r <= SH_LL;
        end else if (load) begin
            work_r <= load_val;
            cnt_r  <= load_cnt;
            mode_r <= load_mode;
        end else if (step) begin
            work_r <= step_val;
            cnt_r  <= cnt_r - CNT_ONE;
        end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
            mode_r <= mode_r;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter
// Execute-stage ALU with a valid/ready handshake on both sides.
// Add, logic, compare, copy and zero-amount shifts take one cycle.
// Shifts by N>0 run one bit per cycle in alu_iter_shift and take N+1 cycles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset. Aborts any operation in flight.
//   bus   : alu_iter_if.slave (in_valid/in_ready, ALUop, A, B,
//           out_valid/out_ready, result)
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_iter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_next_s;
    logic               out_valid_r;
    logic               in_ready_s;
    logic               accept_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic               slt_s;
    logic               sltu_s;
    logic               load_s;
    logic               step_s;
    logic [WIDTH-1:0]   shift_step_val_s;
    logic               shift_last_s;

    // DONE can retire and accept on the same edge, so the pipeline sees no bubble.
    assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign shamt_s    = bus.B[SHAMT_W-1:0];
    assign slt_s      = ($signed(bus.A) < $signed(bus.B));
    assign sltu_s     = (bus.A < bus.B);

    // Single-cycle datapath. A shift reaching this result has a zero amount, so it returns A.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (bus.ALUop)
            ALU_ADD:    alu_res_s = bus.A + bus.B;
            ALU_SUB:    alu_res_s = bus.A - bus.B;
            ALU_AND:    alu_res_s = bus.A & bus.B;
            ALU_OR:     alu_res_s = bus.A | bus.B;
            ALU_XOR:    alu_res_s = bus.A ^ bus.B;
            ALU_SLT:    alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_SLTU:   alu_res_s = {{(WIDTH-1){1'b0}}, sltu_s};
            ALU_SLL, ALU_SRA, ALU_SRL:
                        alu_res_s = bus.A;
            ALU_COPY_B: alu_res_s = bus.B;
            default:    alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next state and result. A new accept overrides the retire decision made in DONE.
    always_comb begin
        state_next_s  = state_r;
        result_next_s = result_r;
        load_s        = 1'b0;
        step_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_IDLE;
            end
            ST_SHIFT: begin
                step_s = 1'b1;
                if (shift_last_s) begin
                    state_next_s  = ST_DONE;
                    result_next_s = shift_step_val_s;
                end else begin
                    state_next_s  = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            if (is_shift_op(bus.ALUop) && (shamt_s != {SHAMT_W{1'b0}})) begin
                state_next_s = ST_SHIFT;
                load_s       = 1'b1;
            end else begin
                state_next_s  = ST_DONE;
                result_next_s = alu_res_s;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // State, result and out_valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            result_r    <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            result_r    <= result_next_s;
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    alu_iter_shift #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .step      (step_s),
        .load_val  (bus.A),
        .load_cnt  (shamt_s),
        .load_mode (shift_mode_of(bus.ALUop)),
        .step_val  (shift_step_val_s),
        .last_step (shift_last_s)
    );

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter
// Self-checking bench for alu_iter. It runs a table of hand-derived vectors,
// randomized operations checked against an arithmetic reference model, and
// handwritten sequences for back-to-back, stall and reset-abort cases.
module tb_alu_iter;
    import alu_iter_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_iter_if #(.WIDTH(W)) bus();

    alu_iter #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result taken directly from the op definitions.
    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned        sh;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sh = 32'(b[4:0]);
        sa = a;
        sb = b;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = (sa < sb) ? 32'd1 : 32'd0;
            4'd6:    r = (a < b) ? 32'd1 : 32'd0;
            4'd7:    r = a << sh;
            4'd8:    r = 32'(sa >>> sh);
            4'd9:    r = a >> sh;
            4'd10:   r = b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        int l;
        if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && b[4:0] != 5'd0) l = int'(b[4:0]) + 1;
        else l = 1;
        return l;
    endfunction

    // Entry: #1 after a rising edge with the DUT idle. Exit: same alignment, DUT idle.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic busy_ok;
        bus.in_valid  = 1'b1;
        bus.ALUop     = op;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs after the accept edge. The result must not change.
        bus.in_valid = 1'b0;
        bus.ALUop    = 4'($urandom);
        bus.A        = $urandom;
        bus.B        = $urandom;
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        if (exp_lat > 1) check({name, " in_ready low while shifting"}, 32'(busy_ok), 32'd1);
        check({name, " result"}, bus.result, exp_res);
        @(posedge clk); #1;
        check({name, " retire valid/ready"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  op_pool [13];
        logic [31:0] exp_x;
        logic [31:0] exp_o;
        int          stray;

        bus.in_valid  = 1'b0;
        bus.ALUop     = 4'd0;
        bus.A         = 32'd0;
        bus.B         = 32'd0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", 32'(bus.in_ready), 32'd1);
        check("post-reset out_valid", 32'(bus.out_valid), 32'd0);

        // Vector table
        vecs.push_back('{"add_wrap",  ALU_ADD,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1});
        vecs.push_back('{"slt_neg",   ALU_SLT,    32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1});
        vecs.push_back('{"sltu_neg",  ALU_SLTU,   32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1});
        vecs.push_back('{"slt_pos",   ALU_SLT,    32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 1});
        vecs.push_back('{"sra4",      ALU_SRA,    32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 5});
        vecs.push_back('{"srl4",      ALU_SRL,    32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 5});
        vecs.push_back('{"sll0",      ALU_SLL,    32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1});
        vecs.push_back('{"sll_hi_b",  ALU_SLL,    32'h0000_0001, 32'hFFFF_FFE1, 32'h0000_0002, 2});
        vecs.push_back('{"sll31",     ALU_SLL,    32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32});
        vecs.push_back('{"sra31",     ALU_SRA,    32'h8000_0001, 32'h0000_001F, 32'hFFFF_FFFF, 32});
        vecs.push_back('{"sub_wrap",  ALU_SUB,    32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1});
        vecs.push_back('{"and",       ALU_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1});
        vecs.push_back('{"or",        ALU_OR,     32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1});
        vecs.push_back('{"xor",       ALU_XOR,    32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 1});
        vecs.push_back('{"copy_b",    ALU_COPY_B, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1});
        vecs.push_back('{"xxx",       ALU_XXX,    32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1});
        vecs.push_back('{"unlisted",  4'd11,      32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1});
        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        // Randomized ops against the reference model
        op_pool = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15, 4'd12};
        for (int i = 0; i < 60; i++) begin
            rop = op_pool[$urandom_range(0, 12)];
            ra  = $urandom;
            rb  = $urandom;
            run_op("random", rop, ra, rb, model_res(rop, ra, rb), model_lat(rop, rb));
        end

        // Back-to-back XOR then OR with the consumer always ready
        exp_x = model_res(ALU_XOR, 32'h0F0F_1234, 32'h00FF_4321);
        exp_o = model_res(ALU_OR,  32'h1000_0001, 32'h0200_0010);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.ALUop = ALU_XOR; bus.A = 32'h0F0F_1234; bus.B = 32'h00FF_4321;
        @(posedge clk); #1;
        check("b2b first out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b first result", bus.result, exp_x);
        check("b2b in_ready in DONE", 32'(bus.in_ready), 32'd1);
        bus.ALUop = ALU_OR; bus.A = 32'h1000_0001; bus.B = 32'h0200_0010;
        @(posedge clk); #1;
        check("b2b second out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b second result", bus.result, exp_o);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b drain out_valid", 32'(bus.out_valid), 32'd0);

        // Same pair with the consumer stalled for 3 cycles
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ALUop = ALU_XOR; bus.A = 32'h0F0F_1234; bus.B = 32'h00FF_4321;
        @(posedge clk); #1;
        bus.ALUop = ALU_OR; bus.A = 32'h1000_0001; bus.B = 32'h0200_0010;
        for (int i = 0; i < 3; i++) begin
            check("stall out_valid", 32'(bus.out_valid), 32'd1);
            check("stall result held", bus.result, exp_x);
            check("stall in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("stall result after hold", bus.result, exp_x);
        bus.out_ready = 1'b1;
        #1;
        check("stall release in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check("stall second out_valid", 32'(bus.out_valid), 32'd1);
        check("stall second result", bus.result, exp_o);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("stall drain out_valid", 32'(bus.out_valid), 32'd0);

        // Reset two cycles into a 31-bit shift. Load a nonzero result first so the clear is visible.
        run_op("preload", ALU_COPY_B, 32'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
        bus.in_valid = 1'b1; bus.ALUop = ALU_SLL; bus.A = 32'h0000_0001; bus.B = 32'h0000_001F;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        stray = 0;
        for (int i = 0; i < 35; i++) begin
            if (bus.out_valid) stray++;
            @(posedge clk); #1;
        end
        check("abort no stray result", 32'(stray), 32'd0);
        run_op("add_after_reset", ALU_ADD, 32'd3, 32'd4, 32'd7, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
